// File: rtl/ieee_fp_pkg.sv
// ieee_fp_pkg: shared definitions for the parametrised IEEE-754 datapath.
// Provides the word-width derivation, operand classification codes and a
// classifier that works for any exponent/mantissa split. Width-dependent
// constants (qNaN, infinity) are built by each user from its own EXP_W/MAN_W.
package ieee_fp_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    // Word width {sign, exponent, mantissa}.
    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Denormals classify as zero: the datapath flushes them.
    function automatic fp_class_e fp_classify(input logic exp_ones,
                                              input logic exp_zero,
                                              input logic man_zero);
        if (exp_zero)  return CLS_ZERO;
        if (!exp_ones) return CLS_NORM;
        return man_zero ? CLS_INF : CLS_NAN;
    endfunction

endpackage

// File: rtl/ieee_lzc.sv
// ieee_lzc: parametric leading-zero counter.
//   value  in  W          vector to scan (MSB first)
//   count  out CW         number of leading zeros; W when value is all zero
module ieee_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++)
            if (value[i]) count = CW'(W - 1 - i);
    end

endmodule

// File: rtl/ieee_adder_pipelined.sv
// ieee_adder_pipelined: pipelined IEEE-754 adder/subtractor, round to
// nearest even, denormals flushed to zero.
// Pipeline: input register, unpack/swap, align, add, normalize/round.
//   clock_in, reset_in      clock, async active-high reset
//   add_sub_bit             0 = A+B, 1 = A-B
//   inputA, inputB          operands {sign, exponent, mantissa}
//   in_valid / in_ready     input handshake (in_ready = not stalled)
//   outputC                 result
//   out_valid / out_ready   output handshake
//   flag_invalid/overflow/inexact  exception flags, qualified by out_valid
module ieee_adder_pipelined
    import ieee_fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   add_sub_bit,
    input  logic [EXP_W+MAN_W:0]   inputA,
    input  logic [EXP_W+MAN_W:0]   inputB,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [EXP_W+MAN_W:0]   outputC,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   flag_invalid,
    output logic                   flag_overflow,
    output logic                   flag_inexact
);

    localparam int W      = fp_width(EXP_W, MAN_W);
    localparam int MW     = MAN_W + 4;           // {hidden, mantissa, g, r, s}
    localparam int SW     = EXP_W + 2;           // signed exponent during normalize
    localparam int LZ_W   = $clog2(MW + 1);
    localparam int STAGES = 4;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    logic [STAGES:0] vld_pipe;
    logic            en;

    // One global stall: every rank holds while the result waits.
    assign en        = ~(out_valid & ~out_ready);
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];

    // ---------------- rank 0: captured operands ----------------
    logic [W-1:0] r0_a, r0_b;
    logic         r0_sub;

    // ---------------- stage 1: unpack / swap ----------------
    logic             a_sgn, b_sgn, x_sgn, y_sgn, swap, nan_in, inf_in;
    logic [EXP_W-1:0] a_exp, b_exp, x_exp, y_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic [MAN_W:0]   x_man, y_man;
    fp_class_e        a_cls, b_cls;
    logic [W-1:0]     spc_word;

    always_comb begin
        a_sgn = r0_a[W-1];
        b_sgn = r0_b[W-1] ^ r0_sub;
        a_exp = r0_a[W-2 -: EXP_W];
        b_exp = r0_b[W-2 -: EXP_W];
        a_cls = fp_classify(&a_exp, ~|a_exp, ~|r0_a[MAN_W-1:0]);
        b_cls = fp_classify(&b_exp, ~|b_exp, ~|r0_b[MAN_W-1:0]);
        a_man = (a_cls == CLS_ZERO) ? '0 : r0_a[MAN_W-1:0];
        b_man = (b_cls == CLS_ZERO) ? '0 : r0_b[MAN_W-1:0];
        swap  = {b_exp, b_man} > {a_exp, a_man};
        x_sgn = swap ? b_sgn : a_sgn;
        y_sgn = swap ? a_sgn : b_sgn;
        x_exp = swap ? b_exp : a_exp;
        y_exp = swap ? a_exp : b_exp;
        x_man = swap ? {b_cls == CLS_NORM, b_man} : {a_cls == CLS_NORM, a_man};
        y_man = swap ? {a_cls == CLS_NORM, a_man} : {b_cls == CLS_NORM, b_man};
        nan_in = (a_cls == CLS_NAN) || (b_cls == CLS_NAN) ||
                 ((a_cls == CLS_INF) && (b_cls == CLS_INF) && (a_sgn != b_sgn));
        inf_in = (a_cls == CLS_INF) || (b_cls == CLS_INF);
        spc_word = nan_in ? QNAN
                 : {(a_cls == CLS_INF) ? a_sgn : b_sgn, EXP_ONES, {MAN_W{1'b0}}};
    end

    logic             s1_xs, s1_ys, s1_spc, s1_inv;
    logic [EXP_W-1:0] s1_xe, s1_diff;
    logic [MAN_W:0]   s1_xm, s1_ym;
    logic [W-1:0]     s1_sw;

    // ---------------- stage 2: align ----------------
    logic [2*MW-1:0] y_wide;
    logic [MW-1:0]   y_al;

    always_comb begin
        // Lower half collects everything shifted past the sticky position.
        y_wide = {s1_ym, 3'b000, {MW{1'b0}}} >> s1_diff;
        if (int'(s1_diff) >= MAN_W + 3)
            y_al = {{(MW-1){1'b0}}, |s1_ym};
        else
            y_al = {y_wide[2*MW-1:MW+1], y_wide[MW] | (|y_wide[MW-1:0])};
    end

    logic             s2_xs, s2_sub, s2_zs, s2_spc, s2_inv;
    logic [EXP_W-1:0] s2_xe;
    logic [MW-1:0]    s2_x, s2_y;
    logic [W-1:0]     s2_sw;

    // ---------------- stage 3: add ----------------
    logic             s3_xs, s3_zs, s3_spc, s3_inv;
    logic [EXP_W-1:0] s3_xe;
    logic [MW:0]      s3_sum;
    logic [W-1:0]     s3_sw;

    // ---------------- stage 4: normalize / round ----------------
    logic [LZ_W-1:0]  lz;
    logic [MW-1:0]    n;
    logic [SW-1:0]    e_norm, e_fin;
    logic [MAN_W+1:0] rnd;
    logic             carry, rup, uflow, oflow;
    logic [W-1:0]     res_word;
    logic             res_inv, res_ovf, res_inx;

    ieee_lzc #(.W(MW)) u_lzc (.value(s3_sum[MW-1:0]), .count(lz));

    always_comb begin
        carry  = s3_sum[MW];
        n      = carry ? {s3_sum[MW:2], |s3_sum[1:0]} : s3_sum[MW-1:0] << lz;
        e_norm = carry ? SW'(s3_xe) + SW'(1) : SW'(s3_xe) - SW'(lz);
        rup    = n[2] & (n[1] | n[0] | n[3]);
        rnd    = {1'b0, n[MW-1:3]} + (MAN_W+2)'(rup);
        // Top two rounded bits are 01 normally, 10 after a round carry.
        e_fin  = e_norm - SW'(1) + SW'(rnd[MAN_W+1:MAN_W]);
        uflow  = e_norm[SW-1] | (e_norm == '0);
        oflow  = e_fin >= SW'(EXP_ONES);

        res_inv  = 1'b0;
        res_ovf  = 1'b0;
        res_inx  = |n[2:0];
        res_word = {s3_xs, e_fin[EXP_W-1:0], rnd[MAN_W-1:0]};
        if (s3_spc) begin
            res_word = s3_sw;
            res_inv  = s3_inv;
            res_inx  = 1'b0;
        end else if (s3_sum == '0) begin
            res_word = {s3_zs, {(W-1){1'b0}}};
            res_inx  = 1'b0;
        end else if (uflow) begin
            res_word = {s3_xs, {(W-1){1'b0}}};
            res_inx  = 1'b1;
        end else if (oflow) begin
            res_word = {s3_xs, EXP_ONES, {MAN_W{1'b0}}};
            res_ovf  = 1'b1;
            res_inx  = 1'b1;
        end
    end

    // Datapath ranks carry no reset: only the valid chain qualifies them.
    always_ff @(posedge clock_in) begin
        if (en) begin
            r0_a    <= inputA;
            r0_b    <= inputB;
            r0_sub  <= add_sub_bit;

            s1_xs   <= x_sgn;
            s1_ys   <= y_sgn;
            s1_xe   <= x_exp;
            s1_xm   <= x_man;
            s1_ym   <= y_man;
            s1_diff <= x_exp - y_exp;
            s1_spc  <= nan_in | inf_in;
            s1_inv  <= nan_in;
            s1_sw   <= spc_word;

            s2_xs   <= s1_xs;
            s2_sub  <= s1_xs ^ s1_ys;
            s2_zs   <= s1_xs & s1_ys;   // only (-0)+(-0) keeps a negative zero
            s2_xe   <= s1_xe;
            s2_x    <= {s1_xm, 3'b000};
            s2_y    <= y_al;
            s2_spc  <= s1_spc;
            s2_inv  <= s1_inv;
            s2_sw   <= s1_sw;

            s3_xs   <= s2_xs;
            s3_zs   <= s2_zs;
            s3_xe   <= s2_xe;
            s3_sum  <= s2_sub ? {1'b0, s2_x} - {1'b0, s2_y}
                              : {1'b0, s2_x} + {1'b0, s2_y};
            s3_spc  <= s2_spc;
            s3_inv  <= s2_inv;
            s3_sw   <= s2_sw;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            vld_pipe      <= '0;
            outputC       <= '0;
            flag_invalid  <= 1'b0;
            flag_overflow <= 1'b0;
            flag_inexact  <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
            if (vld_pipe[STAGES-1]) begin
                outputC       <= res_word;
                flag_invalid  <= res_inv;
                flag_overflow <= res_ovf;
                flag_inexact  <= res_inx;
            end
        end
    end

endmodule

// File: tb/tb_ieee_adder_pipelined.sv
module tb_ieee_adder_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic        sub, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, c;
    logic        f_inv, f_ovf, f_inx;
    logic        sub16, iv16, ir16, ov16, or16;
    logic [15:0] a16, b16, c16;
    logic        fi16, fo16, fx16;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] bp_a [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] bp_c [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                              32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    always #5 clk = ~clk;

    ieee_adder_pipelined u32 (
        .clock_in(clk), .reset_in(rst), .add_sub_bit(sub),
        .inputA(a), .inputB(b), .in_valid(in_valid), .in_ready(in_ready),
        .outputC(c), .out_valid(out_valid), .out_ready(out_ready),
        .flag_invalid(f_inv), .flag_overflow(f_ovf), .flag_inexact(f_inx)
    );

    ieee_adder_pipelined #(.EXP_W(5), .MAN_W(10)) u16 (
        .clock_in(clk), .reset_in(rst), .add_sub_bit(sub16),
        .inputA(a16), .inputB(b16), .in_valid(iv16), .in_ready(ir16),
        .outputC(c16), .out_valid(ov16), .out_ready(or16),
        .flag_invalid(fi16), .flag_overflow(fo16), .flag_inexact(fx16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One isolated operation; latency counted from the accepting edge.
    task automatic op32(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic [31:0] ec, input logic [2:0] ef);
        int lat;
        @(negedge clk);
        a = ia; b = ib; sub = isub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_c"}, c, ec);
        chk({tag, "_flags"}, {f_inv, f_ovf, f_inx}, ef);
    endtask

    task automatic op16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, input logic [15:0] ec);
        int lat;
        @(negedge clk);
        a16 = ia; b16 = ib; sub16 = isub; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_c"}, c16, ec);
        chk({tag, "_flags"}, {fi16, fo16, fx16}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic saw;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; a = '0; b = '0;
        iv16 = 1'b0; or16 = 1'b1; sub16 = 1'b0; a16 = '0; b16 = '0;
        #12;
        chk("rst_vld", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_flags", {f_inv, f_ovf, f_inx}, 0);
        chk("rst_inrdy", in_ready, 1);
        chk("rst_vld16", ov16, 0);
        @(negedge clk);
        rst = 1'b0;

        op32("add",     32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000, 3'b000);
        op32("sub_eq",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        op32("negz",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        op32("inf_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        op32("ovf",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        op32("tie_ev",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        op32("tie_od",  32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
        op32("inf_fin", 32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 3'b000);
        op32("nan",     32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        op32("sub_neg", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
        op32("sub_pos", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
        op32("uflow",   32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001);
        op16("h_add",   16'h3C00, 16'h3C00, 1'b0, 16'h4000);
        op16("h_sub",   16'h4000, 16'h3C00, 1'b1, 16'h3C00);

        // Back-pressure: 8 back-to-back ops, consumer stalls 5 cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    a = bp_a[i]; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
                    #4;
                    while (!in_ready) begin
                        @(negedge clk); #4;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                int k, cyc;
                logic stalled;
                k = 0; cyc = 0; stalled = 1'b0;
                while (k < 8 && cyc < 60) begin
                    @(negedge clk);
                    out_ready = !(cyc >= 6 && cyc < 11);
                    #4;
                    if (out_valid) begin
                        chk("bp_c", c, bp_c[k]);
                        if (!out_ready) begin
                            if (!stalled) chk("bp_inrdy", in_ready, 0);
                            stalled = 1'b1;
                        end else begin
                            k++;
                        end
                    end
                    cyc++;
                end
                chk("bp_cnt", k, 8);
                chk("bp_stalled", stalled, 1);
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1 chk("bp_drain", out_valid, 0);

        // Reset with 3 ops in flight, first one parked at the output.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = bp_a[i]; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("mr_pre", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mr_vld", out_valid, 0);
        chk("mr_c", c, 0);
        chk("mr_inrdy", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1'b1;
        end
        chk("mr_flush", saw, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
